bus_loader: RTL and testbench

BUS_LOADER -- requirements
Module: bus_loader

---
 rtl/bus_loader_pkg.sv | 20 ++
 rtl/bus_loader_uart_rx.sv | 92 +++++++++
 rtl/bus_loader.sv | 144 ++++++++++++++
 tb/tb_bus_loader.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_loader_pkg.sv
// Shared types and defaults for the UART-driven memory loader.
package bus_loader_pkg;

   localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

   typedef enum logic [1:0] {
      StHdrHi,
      StHdrLo,
      StWord,
      StWrite
   } loader_state_e;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } rx_state_e;

endpackage

// File: rtl/bus_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle valid/frameErr strobes.
module uart_rx
   import bus_loader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       valid,
   output logic       frameErr
);

   localparam logic [15:0] HalfMax = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] BitMax  = 16'(CLKS_PER_BIT - 1);

   logic [1:0]  sync_q;
   rx_state_e   state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        rx_s;

   assign rx_s    = sync_q[1];
   assign rx_byte = shift_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= 2'b11;
         state_q <= StIdle;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         sync_q  <= {sync_q[0], rx};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      valid    = 1'b0;
      frameErr = 1'b0;
      case (state_q)
         StIdle: begin
            if (!rx_s) begin
               state_d = StStart;
               cnt_d   = '0;
            end
         end
         StStart: begin
            if (cnt_q == HalfMax) begin
               cnt_d   = '0;
               bit_d   = '0;
               // A line that is high again at mid-start-bit was only a glitch.
               state_d = rx_s ? StIdle : StData;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StData: begin
            if (cnt_q == BitMax) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = StStop;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StStop: begin
            if (cnt_q == BitMax) begin
               cnt_d    = '0;
               state_d  = StIdle;
               valid    = rx_s;
               frameErr = !rx_s;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: rtl/bus_loader.sv
// Loads a length-prefixed stream of big-endian 32-bit words from UART into memory from address 0.
module bus_loader
   import bus_loader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   output logic [15:0] address,
   output logic [31:0] data,
   output logic        wren,
   input  logic        stall,
   output logic        holdCpu,
   output logic        done,
   output logic        error
);

   logic [7:0]    rx_byte;
   logic          rx_valid, rx_ferr;
   loader_state_e state_q, state_d;
   logic [15:0]   count_q, count_d, addr_q, addr_d;
   logic [31:0]   data_q, data_d;
   logic [1:0]    idx_q, idx_d;
   logic          wren_q, wren_d, hold_q, hold_d, done_q, done_d, error_q, error_d;

   uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart_rx (
      .clk     (clk),
      .rst     (rst),
      .rx      (rx),
      .rx_byte (rx_byte),
      .valid   (rx_valid),
      .frameErr(rx_ferr)
   );

   assign address = addr_q;
   assign data    = data_q;
   assign wren    = wren_q;
   assign holdCpu = hold_q;
   assign done    = done_q;
   assign error   = error_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StHdrHi;
         count_q <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         idx_q   <= '0;
         wren_q  <= 1'b0;
         hold_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         wren_q  <= wren_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      addr_d  = addr_q;
      data_d  = data_q;
      idx_d   = idx_q;
      wren_d  = wren_q;
      hold_d  = hold_q;
      done_d  = 1'b0;
      error_d = error_q;
      // A framing error outranks everything, including a write completing this cycle.
      if (rx_ferr) begin
         error_d = 1'b1;
         wren_d  = 1'b0;
         hold_d  = 1'b0;
         state_d = StHdrHi;
      end else begin
         case (state_q)
            StHdrHi: begin
               if (rx_valid) begin
                  count_d[15:8] = rx_byte;
                  hold_d        = 1'b1;
                  error_d       = 1'b0;
                  state_d       = StHdrLo;
               end
            end
            StHdrLo: begin
               if (rx_valid) begin
                  count_d[7:0] = rx_byte;
                  addr_d       = '0;
                  idx_d        = '0;
                  if ({count_q[15:8], rx_byte} == 16'd0) begin
                     done_d  = 1'b1;
                     hold_d  = 1'b0;
                     state_d = StHdrHi;
                  end else begin
                     state_d = StWord;
                  end
               end
            end
            StWord: begin
               if (rx_valid) begin
                  data_d = {data_q[23:0], rx_byte};
                  idx_d  = idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                     wren_d  = 1'b1;
                     state_d = StWrite;
                  end
               end
            end
            StWrite: begin
               if (rx_valid) begin
                  // Overrun: a new byte arrived before the responder accepted the word.
                  error_d = 1'b1;
                  wren_d  = 1'b0;
                  hold_d  = 1'b0;
                  state_d = StHdrHi;
               end else if (!stall) begin
                  wren_d = 1'b0;
                  addr_d = addr_q + 16'd1;
                  idx_d  = '0;
                  if (addr_q + 16'd1 == count_q) begin
                     done_d  = 1'b1;
                     hold_d  = 1'b0;
                     state_d = StHdrHi;
                  end else begin
                     state_d = StWord;
                  end
               end
            end
            default: state_d = StHdrHi;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_loader.sv
// Directed bench for bus_loader at 16 clocks per UART bit.
module tb_bus_loader;

   localparam int Cpb = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx = 1'b1;
   logic        stall = 1'b0;
   logic [15:0] address;
   logic [31:0] data;
   logic        wren, holdCpu, done, error;

   bus_loader #(
      .CLKS_PER_BIT(Cpb)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .rx     (rx),
      .address(address),
      .data   (data),
      .wren   (wren),
      .stall  (stall),
      .holdCpu(holdCpu),
      .done   (done),
      .error  (error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass = 0;
   int n_wr = 0;
   int n_done = 0;
   int wren_hi = 0;
   int unstable = 0;
   int both = 0;
   int hold_bad = 0;
   int stall_budget = 0;
   bit stall_hold = 1'b0;
   logic [15:0] wr_addr [16];
   logic [31:0] wr_data [16];
   logic        prev_wren = 1'b0;
   logic [15:0] prev_addr = '0;
   logic [31:0] prev_data = '0;

   // Stall driver and bus monitor; stall set here is what the next rising edge sees.
   always @(negedge clk) begin
      if (stall_hold) stall = 1'b1;
      else if (stall_budget > 0 && wren) begin
         stall = 1'b1;
         stall_budget--;
      end else stall = 1'b0;
      if (!rst) begin
         if (wren) begin
            wren_hi++;
            if (prev_wren && (address != prev_addr || data != prev_data)) unstable++;
         end
         if (wren && !stall && n_wr < 16) begin
            wr_addr[n_wr] = address;
            wr_data[n_wr] = data;
            n_wr++;
         end
         if (done) begin
            n_done++;
            if (holdCpu) hold_bad++;
            if (error) both++;
         end
      end
      prev_wren = wren;
      prev_addr = address;
      prev_data = data;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge clk);
      rx = 1'b0;
      repeat (Cpb) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (Cpb) @(negedge clk);
      end
      rx = stop_bit;
      repeat (Cpb) @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   logic [7:0] s_main [10] = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                               8'h01, 8'h02, 8'h03, 8'h04};
   logic [7:0] s_one  [6]  = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
   logic [7:0] s_cafe [6]  = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
   int b_wr, b_done, b_hi;

   initial begin
      rst = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_address", 32'(address), 32'h0);
      check("rst_data", data, 32'h0);
      check("rst_wren", 32'(wren), 32'h0);
      check("rst_hold", 32'(holdCpu), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_error", 32'(error), 32'h0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Two words, no stall.
      b_wr = n_wr; b_done = n_done;
      send_byte(s_main[0], 1'b1);
      check("t1_hold_hi", 32'(holdCpu), 32'h1);
      for (int i = 1; i < 10; i++) send_byte(s_main[i], 1'b1);
      check("t1_nwr", 32'(n_wr - b_wr), 32'd2);
      check("t1_addr0", 32'(wr_addr[b_wr]), 32'h0);
      check("t1_data0", wr_data[b_wr], 32'hDEADBEEF);
      check("t1_addr1", 32'(wr_addr[b_wr + 1]), 32'h1);
      check("t1_data1", wr_data[b_wr + 1], 32'h01020304);
      check("t1_ndone", 32'(n_done - b_done), 32'd1);
      check("t1_error", 32'(error), 32'h0);
      check("t1_hold_lo", 32'(holdCpu), 32'h0);

      // Same stream with the first write stalled for 5 cycles.
      b_wr = n_wr; b_done = n_done; b_hi = wren_hi;
      stall_budget = 5;
      for (int i = 0; i < 10; i++) send_byte(s_main[i], 1'b1);
      check("t2_nwr", 32'(n_wr - b_wr), 32'd2);
      check("t2_wren_cycles", 32'(wren_hi - b_hi), 32'd7);
      check("t2_data0", wr_data[b_wr], 32'hDEADBEEF);
      check("t2_addr1", 32'(wr_addr[b_wr + 1]), 32'h1);
      check("t2_data1", wr_data[b_wr + 1], 32'h01020304);
      check("t2_ndone", 32'(n_done - b_done), 32'd1);

      // Zero-length load.
      b_wr = n_wr; b_done = n_done;
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      check("t3_ndone", 32'(n_done - b_done), 32'd1);
      check("t3_nwr", 32'(n_wr - b_wr), 32'd0);
      check("t3_hold", 32'(holdCpu), 32'h0);

      // Framing error, then a clean one-word load.
      b_wr = n_wr; b_done = n_done;
      send_byte(8'h00, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'hAA, 1'b0);
      check("t4_error_set", 32'(error), 32'h1);
      check("t4_hold_lo", 32'(holdCpu), 32'h0);
      check("t4_nwr_err", 32'(n_wr - b_wr), 32'd0);
      send_byte(s_one[0], 1'b1);
      check("t4_error_clr", 32'(error), 32'h0);
      check("t4_hold_hi", 32'(holdCpu), 32'h1);
      for (int i = 1; i < 6; i++) send_byte(s_one[i], 1'b1);
      check("t4_nwr", 32'(n_wr - b_wr), 32'd1);
      check("t4_addr", 32'(wr_addr[b_wr]), 32'h0);
      check("t4_data", wr_data[b_wr], 32'h11223344);
      check("t4_ndone", 32'(n_done - b_done), 32'd1);

      // Short glitch is ignored; then an overrun while the responder stalls.
      @(negedge clk);
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      check("t5_glitch_hold", 32'(holdCpu), 32'h0);
      check("t5_glitch_err", 32'(error), 32'h0);
      b_wr = n_wr;
      stall_hold = 1'b1;
      send_byte(8'h00, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b1);
      send_byte(8'hCC, 1'b1);
      send_byte(8'hDD, 1'b1);
      check("t5_wren_pending", 32'(wren), 32'h1);
      check("t5_data_pending", data, 32'hAABBCCDD);
      send_byte(8'h11, 1'b1);
      check("t5_ovr_error", 32'(error), 32'h1);
      check("t5_ovr_wren", 32'(wren), 32'h0);
      check("t5_ovr_hold", 32'(holdCpu), 32'h0);
      check("t5_ovr_nwr", 32'(n_wr - b_wr), 32'd0);
      stall_hold = 1'b0;
      repeat (5) @(negedge clk);

      // Reset mid-load abandons progress.
      b_wr = n_wr;
      for (int i = 0; i < 5; i++) send_byte(s_one[i], 1'b1);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("t6_rst_data", data, 32'h0);
      check("t6_rst_hold", 32'(holdCpu), 32'h0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      for (int i = 0; i < 6; i++) send_byte(s_cafe[i], 1'b1);
      check("t6_nwr", 32'(n_wr - b_wr), 32'd1);
      check("t6_addr", 32'(wr_addr[b_wr]), 32'h0);
      check("t6_data", wr_data[b_wr], 32'hCAFEBABE);

      check("all_unstable", 32'(unstable), 32'd0);
      check("all_done_err", 32'(both), 32'd0);
      check("all_hold_at_done", 32'(hold_bad), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
